reset_release_sequencer: RTL and testbench



---
 rtl/reset_release_sequencer.sv | 136 +++++++++++++
 tb/tb_reset_release_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer
//   Takes the synchronized active-low reset and releases N_STAGES downstream
//   reset domains in order (stage 0 first). The first stage is released
//   INIT_CYCLES after as_rst goes high, and each later stage follows STAGE_GAP
//   cycles after the previous one. Once every stage is out of reset, a
//   software request pulls all stages low for SW_RST_CYCLES and then runs the
//   release sequence again.
//
// Ports
//   clk         system clock
//   as_rst      active-low reset from the synchronizer; asserts asynchronously
//   hold        in ASSERT, 1 freezes the initial count
//   sw_rst_req  software reset request, sampled every cycle, accepted only in DONE
//   rst_n_out   per-stage active-low reset, bit k drives domain k
//   seq_done    1 while all stages are released
//   sw_rst_ack  one-cycle pulse on the edge that accepts sw_rst_req
//   stage_idx   number of stages currently released
module reset_release_sequencer #(
    parameter int N_STAGES      = 3,
    parameter int INIT_CYCLES   = 16,
    parameter int STAGE_GAP     = 8,
    parameter int SW_RST_CYCLES = 4
) (
    input  logic                              clk,
    input  logic                              as_rst,
    input  logic                              hold,
    input  logic                              sw_rst_req,
    output logic [N_STAGES-1:0]               rst_n_out,
    output logic                              seq_done,
    output logic                              sw_rst_ack,
    output logic [$clog2(N_STAGES+1)-1:0]     stage_idx
);

    localparam int MAX_AB = (INIT_CYCLES > STAGE_GAP) ? INIT_CYCLES : STAGE_GAP;
    localparam int MAX_C  = (MAX_AB > SW_RST_CYCLES) ? MAX_AB : SW_RST_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C) + 1;
    localparam int SIDX_W = $clog2(N_STAGES + 1);

    localparam logic [CNT_W-1:0]  INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0]  SW_LAST   = CNT_W'(SW_RST_CYCLES - 1);
    localparam logic [SIDX_W-1:0] IDX_LAST  = SIDX_W'(N_STAGES - 1);

    typedef enum logic [1:0] {ASSERT, RELEASE, DONE, SWRST} state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [N_STAGES-1:0] rst_d;
    logic                done_d, ack_d;
    logic [SIDX_W-1:0]   idx_d;

    always_ff @(posedge clk or negedge as_rst) begin
        if (!as_rst) begin
            state      <= ASSERT;
            cnt        <= '0;
            rst_n_out  <= '0;
            seq_done   <= 1'b0;
            sw_rst_ack <= 1'b0;
            stage_idx  <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            rst_n_out  <= rst_d;
            seq_done   <= done_d;
            sw_rst_ack <= ack_d;
            stage_idx  <= idx_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rst_d   = rst_n_out;
        done_d  = seq_done;
        ack_d   = 1'b0;
        idx_d   = stage_idx;
        unique case (state)
            ASSERT: begin
                if (!hold) begin
                    if (cnt == INIT_LAST) begin
                        rst_d[0] = 1'b1;
                        idx_d    = SIDX_W'(1);
                        cnt_d    = '0;
                        if (N_STAGES == 1) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            RELEASE: begin
                if (cnt == GAP_LAST) begin
                    // stage_idx is the count released so far, so it is
                    // also the index of the next stage to release.
                    for (int k = 0; k < N_STAGES; k++)
                        if (stage_idx == SIDX_W'(k)) rst_d[k] = 1'b1;
                    idx_d = stage_idx + SIDX_W'(1);
                    cnt_d = '0;
                    if (stage_idx == IDX_LAST) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                if (sw_rst_req) begin
                    rst_d   = '0;
                    done_d  = 1'b0;
                    idx_d   = '0;
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = SWRST;
                end
            end
            SWRST: begin
                if (cnt == SW_LAST) begin
                    cnt_d   = '0;
                    state_d = ASSERT;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = ASSERT;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer. Edge numbers in the tasks count
// rising edges after the reference point that each scenario describes. The
// main instance uses default parameters. A second instance (N_STAGES=1,
// INIT_CYCLES=1) covers the single-stage case.
module tb_reset_release_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       as_rst, hold, sw_rst_req;
    logic [2:0] rst_n_out;
    logic       seq_done, sw_rst_ack;
    logic [1:0] stage_idx;

    logic       as_rst1, hold1, sw_rst_req1;
    logic [0:0] rst_n_out1;
    logic       seq_done1, sw_rst_ack1;
    logic [0:0] stage_idx1;

    int vectors    = 0;
    int miscompares = 0;
    int edge_n     = 0;

    reset_release_sequencer dut (
        .clk(clk), .as_rst(as_rst), .hold(hold), .sw_rst_req(sw_rst_req),
        .rst_n_out(rst_n_out), .seq_done(seq_done), .sw_rst_ack(sw_rst_ack),
        .stage_idx(stage_idx)
    );

    reset_release_sequencer #(.N_STAGES(1), .INIT_CYCLES(1)) dut1 (
        .clk(clk), .as_rst(as_rst1), .hold(hold1), .sw_rst_req(sw_rst_req1),
        .rst_n_out(rst_n_out1), .seq_done(seq_done1), .sw_rst_ack(sw_rst_ack1),
        .stage_idx(stage_idx1)
    );

    // Advance to 1 time unit after edge e; inputs change only at that point.
    task automatic adv_to(int e);
        while (edge_n < e) begin
            @(posedge clk);
            #1;
            edge_n++;
        end
    endtask

    // as_rst goes high just after the next edge, and that edge is edge 0.
    task automatic release_at_edge();
        @(posedge clk);
        #1;
        as_rst = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({rst_n_out, seq_done, sw_rst_ack, stage_idx} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset: rst=%b done=%b ack=%b idx=%0d, want all 0",
                     rst_n_out, seq_done, sw_rst_ack, stage_idx);
        end
        vectors++;
        if ({rst_n_out1, seq_done1, sw_rst_ack1, stage_idx1} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_n1: rst=%b done=%b ack=%b idx=%0d, want all 0",
                     rst_n_out1, seq_done1, sw_rst_ack1, stage_idx1);
        end
    endtask

    task automatic test_powerup();
        int         ed[6] = '{15, 16, 23, 24, 31, 32};
        logic [2:0] er[6] = '{3'b000, 3'b001, 3'b001, 3'b011, 3'b011, 3'b111};
        logic       ek[6] = '{0, 0, 0, 0, 0, 1};
        logic [1:0] ei[6] = '{0, 1, 1, 2, 2, 3};
        release_at_edge();
        for (int i = 0; i < 6; i++) begin
            adv_to(ed[i]);
            vectors++;
            if ({rst_n_out, seq_done, sw_rst_ack, stage_idx} !== {er[i], ek[i], 1'b0, ei[i]}) begin
                miscompares++;
                $display("FAIL powerup edge %0d: rst=%b done=%b ack=%b idx=%0d, want rst=%b done=%b ack=0 idx=%0d",
                         ed[i], rst_n_out, seq_done, sw_rst_ack, stage_idx, er[i], ek[i], ei[i]);
            end
        end
    endtask

    task automatic test_hold();
        int         ed[6] = '{25, 26, 33, 34, 41, 42};
        logic [2:0] er[6] = '{3'b000, 3'b001, 3'b001, 3'b011, 3'b011, 3'b111};
        logic       ek[6] = '{0, 0, 0, 0, 0, 1};
        logic [1:0] ei[6] = '{0, 1, 1, 2, 2, 3};
        as_rst = 1'b0;
        #1;
        vectors++;
        if ({rst_n_out, seq_done, stage_idx} !== 6'b0) begin
            miscompares++;
            $display("FAIL async_assert_done: rst=%b done=%b idx=%0d, want all 0",
                     rst_n_out, seq_done, stage_idx);
        end
        hold = 1'b1;
        release_at_edge();
        adv_to(10);
        hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            adv_to(ed[i]);
            vectors++;
            if ({rst_n_out, seq_done, sw_rst_ack, stage_idx} !== {er[i], ek[i], 1'b0, ei[i]}) begin
                miscompares++;
                $display("FAIL hold edge %0d: rst=%b done=%b ack=%b idx=%0d, want rst=%b done=%b ack=0 idx=%0d",
                         ed[i], rst_n_out, seq_done, sw_rst_ack, stage_idx, er[i], ek[i], ei[i]);
            end
        end
    endtask

    // Request is sampled at edge T=46.
    task automatic test_sw_reset();
        int         ed[6] = '{47, 65, 66, 74, 81, 82};
        logic [2:0] er[6] = '{3'b000, 3'b000, 3'b001, 3'b011, 3'b011, 3'b111};
        logic       ek[6] = '{0, 0, 0, 0, 0, 1};
        logic [1:0] ei[6] = '{0, 0, 1, 2, 2, 3};
        adv_to(45);
        sw_rst_req = 1'b1;
        adv_to(46);
        sw_rst_req = 1'b0;
        vectors++;
        if ({rst_n_out, seq_done, sw_rst_ack, stage_idx} !== {3'b000, 1'b0, 1'b1, 2'd0}) begin
            miscompares++;
            $display("FAIL sw_accept: rst=%b done=%b ack=%b idx=%0d, want rst=000 done=0 ack=1 idx=0",
                     rst_n_out, seq_done, sw_rst_ack, stage_idx);
        end
        for (int i = 0; i < 6; i++) begin
            adv_to(ed[i]);
            vectors++;
            if ({rst_n_out, seq_done, sw_rst_ack, stage_idx} !== {er[i], ek[i], 1'b0, ei[i]}) begin
                miscompares++;
                $display("FAIL sw_reset edge %0d: rst=%b done=%b ack=%b idx=%0d, want rst=%b done=%b ack=0 idx=%0d",
                         ed[i], rst_n_out, seq_done, sw_rst_ack, stage_idx, er[i], ek[i], ei[i]);
            end
        end
    endtask

    task automatic test_async_abort();
        as_rst = 1'b0;
        release_at_edge();
        adv_to(20);
        vectors++;
        if ({rst_n_out, stage_idx} !== {3'b001, 2'd1}) begin
            miscompares++;
            $display("FAIL abort_pre edge 20: rst=%b idx=%0d, want rst=001 idx=1", rst_n_out, stage_idx);
        end
        #1 as_rst = 1'b0;
        #1;
        vectors++;
        if ({rst_n_out, seq_done, sw_rst_ack, stage_idx} !== 7'b0) begin
            miscompares++;
            $display("FAIL abort_async: rst=%b done=%b ack=%b idx=%0d, want all 0",
                     rst_n_out, seq_done, sw_rst_ack, stage_idx);
        end
        adv_to(22);
        as_rst = 1'b1;
        adv_to(37);
        vectors++;
        if (rst_n_out !== 3'b000) begin
            miscompares++;
            $display("FAIL abort edge 37: rst=%b, want 000", rst_n_out);
        end
        adv_to(38);
        vectors++;
        if ({rst_n_out, stage_idx} !== {3'b001, 2'd1}) begin
            miscompares++;
            $display("FAIL abort edge 38: rst=%b idx=%0d, want rst=001 idx=1", rst_n_out, stage_idx);
        end
    endtask

    // Continues from the abort scenario, which is now in RELEASE after edge 38.
    // The request goes high after edge 40 and drops after its ack at edge 55.
    task automatic test_req_held();
        int acks = 0;
        adv_to(40);
        sw_rst_req = 1'b1;
        for (int e = 41; e <= 91; e++) begin
            adv_to(e);
            if (sw_rst_ack === 1'b1) acks++;
            vectors++;
            if (sw_rst_ack !== (e == 55)) begin
                miscompares++;
                $display("FAIL req_held ack edge %0d: ack=%b, want %b", e, sw_rst_ack, (e == 55));
            end
            if (e == 54) begin
                vectors++;
                if ({rst_n_out, seq_done} !== {3'b111, 1'b1}) begin
                    miscompares++;
                    $display("FAIL req_held edge 54: rst=%b done=%b, want rst=111 done=1", rst_n_out, seq_done);
                end
            end
            if (e == 55) begin
                sw_rst_req = 1'b0;
                vectors++;
                if ({rst_n_out, seq_done} !== {3'b000, 1'b0}) begin
                    miscompares++;
                    $display("FAIL req_held edge 55: rst=%b done=%b, want rst=000 done=0", rst_n_out, seq_done);
                end
            end
            if (e == 74 || e == 75) begin
                vectors++;
                if (rst_n_out !== ((e == 75) ? 3'b001 : 3'b000)) begin
                    miscompares++;
                    $display("FAIL req_held edge %0d: rst=%b, want %b", e, rst_n_out, (e == 75) ? 3'b001 : 3'b000);
                end
            end
        end
        vectors++;
        if ({rst_n_out, seq_done, stage_idx} !== {3'b111, 1'b1, 2'd3}) begin
            miscompares++;
            $display("FAIL req_held edge 91: rst=%b done=%b idx=%0d, want rst=111 done=1 idx=3",
                     rst_n_out, seq_done, stage_idx);
        end
        vectors++;
        if (acks != 1) begin
            miscompares++;
            $display("FAIL req_held ack_count: got %0d, want 1", acks);
        end
    endtask

    task automatic test_single_stage();
        @(posedge clk);
        #1 as_rst1 = 1'b1;
        vectors++;
        if ({rst_n_out1, seq_done1} !== 2'b00) begin
            miscompares++;
            $display("FAIL n1 pre-edge: rst=%b done=%b, want 0 0", rst_n_out1, seq_done1);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({rst_n_out1, seq_done1, sw_rst_ack1, stage_idx1} !== 4'b1101) begin
            miscompares++;
            $display("FAIL n1 edge 1: rst=%b done=%b ack=%b idx=%0d, want rst=1 done=1 ack=0 idx=1",
                     rst_n_out1, seq_done1, sw_rst_ack1, stage_idx1);
        end
        // The software reset is accepted at edge 2, and stage 0 returns at 2+4+1=7.
        sw_rst_req1 = 1'b1;
        @(posedge clk);
        #1 sw_rst_req1 = 1'b0;
        vectors++;
        if ({rst_n_out1, seq_done1, sw_rst_ack1, stage_idx1} !== 4'b0010) begin
            miscompares++;
            $display("FAIL n1 sw_accept: rst=%b done=%b ack=%b idx=%0d, want rst=0 done=0 ack=1 idx=0",
                     rst_n_out1, seq_done1, sw_rst_ack1, stage_idx1);
        end
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if ({rst_n_out1, sw_rst_ack1} !== 2'b00) begin
            miscompares++;
            $display("FAIL n1 edge 6: rst=%b ack=%b, want 0 0", rst_n_out1, sw_rst_ack1);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({rst_n_out1, seq_done1, stage_idx1} !== 3'b111) begin
            miscompares++;
            $display("FAIL n1 edge 7: rst=%b done=%b idx=%0d, want 1 1 1", rst_n_out1, seq_done1, stage_idx1);
        end
    endtask

    initial begin
        as_rst = 1'b0; hold = 1'b0; sw_rst_req = 1'b0;
        as_rst1 = 1'b0; hold1 = 1'b0; sw_rst_req1 = 1'b0;
        test_reset();
        test_powerup();
        test_hold();
        test_sw_reset();
        test_async_abort();
        test_req_held();
        test_single_stage();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
